// File: rtl/ioctl_stream_source.sv
// ioctl_stream_source: replays a byte image from a source memory as an ioctl download, honouring ioctl_wait.
// Optional feature macro: IOCTL_SRC_CHECKSUM_EN adds o_checksum (mod-256 sum of every byte written).
// Ports:
//   i_clk_sys          clock, all logic on posedge
//   i_reset_n          synchronous active-low reset
//   i_start            1-cycle request, honoured only when idle
//   i_index            image index, latched on start (0=BIOS, else cart)
//   i_length           byte count, latched on start
//   o_src_rd           source read strobe
//   o_src_addr         source byte address
//   i_src_data         source data, valid one cycle after o_src_rd
//   o_ioctl_download   transfer window
//   o_ioctl_index      latched index
//   o_ioctl_addr       byte address of current write
//   o_ioctl_dout       byte being written
//   o_ioctl_wr         1-cycle write strobe
//   i_ioctl_wait       sink stall request, only looked at while writing
//   o_busy             high whenever not idle
//   o_done             1-cycle pulse at end of transfer
//   o_checksum         running byte sum (IOCTL_SRC_CHECKSUM_EN only)
module ioctl_stream_source #(
  parameter int ADDR_W      = 25,
  parameter int WR_GAP      = 2,
  parameter int TAIL_CYCLES = 4
) (
  input  logic              i_clk_sys,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [7:0]        i_index,
  input  logic [ADDR_W-1:0] i_length,
  output logic              o_src_rd,
  output logic [ADDR_W-1:0] o_src_addr,
  input  logic [7:0]        i_src_data,
  output logic              o_ioctl_download,
  output logic [7:0]        o_ioctl_index,
  output logic [ADDR_W-1:0] o_ioctl_addr,
  output logic [7:0]        o_ioctl_dout,
  output logic              o_ioctl_wr,
  input  logic              i_ioctl_wait,
  output logic              o_busy,
`ifdef IOCTL_SRC_CHECKSUM_EN
  output logic [7:0]        o_checksum,
`endif
  output logic              o_done
);
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_FETCH, S_LATCH, S_WRITE, S_GAP, S_TAIL} state_t;
  localparam logic [15:0] GAP_END  = 16'(WR_GAP);
  localparam logic [15:0] TAIL_END = 16'(TAIL_CYCLES - 1);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_len, r_cnt, r_addr;
  logic [7:0] r_index, r_dout;
  logic [15:0] r_tmr;
  logic r_done, w_start_idle, w_last;
  assign w_start_idle     = i_start && r_state == S_IDLE;
  assign w_last           = r_cnt == r_len - ADDR_W'(1);
  assign o_src_addr       = r_cnt;
  assign o_ioctl_download = r_state != S_IDLE;
  assign o_busy           = r_state != S_IDLE;
  assign o_ioctl_index    = r_index;
  assign o_ioctl_addr     = r_addr;
  assign o_ioctl_dout     = r_dout;
  assign o_done           = r_done;
  always_ff @(posedge i_clk_sys) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // GAP lasts WR_GAP+1 cycles (the exit transition plus WR_GAP idle cycles).
  always_comb begin
    w_next     = r_state;
    o_src_rd   = 1'b0;
    o_ioctl_wr = 1'b0;
    case (r_state)
      S_IDLE:  w_next = (i_start && i_length != '0) ? S_SETUP : S_IDLE;
      S_SETUP: w_next = S_FETCH;
      S_FETCH: begin
        o_src_rd = 1'b1;
        w_next   = S_LATCH;
      end
      S_LATCH: w_next = S_WRITE;
      S_WRITE: begin
        o_ioctl_wr = !i_ioctl_wait;
        w_next     = i_ioctl_wait ? S_WRITE : S_GAP;
      end
      S_GAP:   w_next = r_tmr != GAP_END ? S_GAP : w_last ? S_TAIL : S_FETCH;
      S_TAIL:  w_next = r_tmr == TAIL_END ? S_IDLE : S_TAIL;
      default: w_next = S_IDLE;
    endcase
  end
  // r_tmr restarts on every state change, so it measures time spent in the current state.
  always_ff @(posedge i_clk_sys) begin
    if (!i_reset_n) begin
      r_len   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_index <= '0;
      r_dout  <= '0;
      r_tmr   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (w_start_idle && i_length == '0) || (r_state == S_TAIL && w_next == S_IDLE);
      r_tmr  <= w_next == r_state ? r_tmr + 16'd1 : 16'd0;
      if (w_start_idle) begin
        r_index <= i_index;
        r_len   <= i_length;
        r_cnt   <= '0;
      end else if (r_state == S_GAP && w_next == S_FETCH) r_cnt <= r_cnt + ADDR_W'(1);
      if (r_state == S_LATCH) begin
        r_dout <= i_src_data;
        r_addr <= r_cnt;
      end
    end
  end
`ifdef IOCTL_SRC_CHECKSUM_EN
  logic [7:0] r_checksum;
  assign o_checksum = r_checksum;
  always_ff @(posedge i_clk_sys) begin
    if (!i_reset_n) r_checksum <= 8'd0;
    else r_checksum <= w_start_idle ? 8'd0 : o_ioctl_wr ? r_checksum + r_dout : r_checksum;
  end
`endif
endmodule

// File: tb/tb_ioctl_stream_source.sv
// tb_ioctl_stream_source: randomized self-checking bench for ioctl_stream_source against a byte-list model.
module tb_ioctl_stream_source;
  localparam int AW = 25, GAP = 2, TAIL = 4;
  localparam int PER = 4 + GAP;
  localparam int FALL = GAP + 1 + TAIL + 1;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, wt = 1'b0;
  logic [7:0] index = 8'd0, src_data = 8'd0;
  logic [AW-1:0] length = '0;
  logic src_rd, dl, wr, busy, done;
  logic [AW-1:0] src_addr, addr;
  logic [7:0] ioidx, dout;
`ifdef IOCTL_SRC_CHECKSUM_EN
  logic [7:0] csum;
`endif
  ioctl_stream_source #(.ADDR_W(AW), .WR_GAP(GAP), .TAIL_CYCLES(TAIL)) dut (
    .i_clk_sys(clk), .i_reset_n(rst_n), .i_start(start), .i_index(index), .i_length(length),
    .o_src_rd(src_rd), .o_src_addr(src_addr), .i_src_data(src_data),
    .o_ioctl_download(dl), .o_ioctl_index(ioidx), .o_ioctl_addr(addr), .o_ioctl_dout(dout),
    .o_ioctl_wr(wr), .i_ioctl_wait(wt), .o_busy(busy),
`ifdef IOCTL_SRC_CHECKSUM_EN
    .o_checksum(csum),
`endif
    .o_done(done)
  );
  always #5 clk = ~clk;
  logic [7:0] mem [256];
  always @(posedge clk) if (src_rd) src_data <= mem[src_addr[7:0]];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [AW-1:0] wa[$];
  logic [7:0] wd[$];
  int wc[$];
  int done_cnt, done_cyc, dl_rise, dl_fall, rd_cnt, dl_cnt;
  logic done_busy, prev_dl = 1'b0;
  logic [7:0] done_ck = 8'd0;
  always @(negedge clk) begin
    if (wr) begin
      wa.push_back(addr);
      wd.push_back(dout);
      wc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_busy = busy;
`ifdef IOCTL_SRC_CHECKSUM_EN
      done_ck = csum;
`endif
    end
    if (!prev_dl && dl) dl_rise = cyc;
    if (prev_dl && !dl) dl_fall = cyc;
    prev_dl = dl;
    if (src_rd) rd_cnt++;
    if (dl) dl_cnt++;
  end
  int pass = 0, total = 0;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic clear_mon();
    wa.delete();
    wd.delete();
    wc.delete();
    done_cnt = 0;
    done_cyc = -1;
    dl_rise = -1;
    dl_fall = -1;
    rd_cnt = 0;
    dl_cnt = 0;
  endtask
  task automatic kick(input logic [7:0] idx, input logic [AW-1:0] len);
    start = 1'b1;
    index = idx;
    length = len;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      tick();
      n++;
    end
    tick(2);
  endtask
  task automatic wait_wr(input int k);
    int n = 0;
    while (wa.size() < k && n < 500) begin
      tick();
      n++;
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    total++;
    if ({dl, wr, busy, done, src_rd, ioidx, addr, dout, src_addr} !== '0)
      $display("FAIL reset_outputs: got %h want 0", {dl, wr, busy, done, src_rd, ioidx, addr, dout, src_addr});
    else pass++;
`ifdef IOCTL_SRC_CHECKSUM_EN
    total++;
    if (csum !== 8'd0) $display("FAIL reset_checksum: got %h want 00", csum); else pass++;
`endif
    rst_n = 1'b1;
    tick(2);
    total++;
    if (busy !== 1'b0 || dl !== 1'b0) $display("FAIL idle_after_reset: busy=%b dl=%b want 0,0", busy, dl); else pass++;
  endtask
  task automatic test_basic();
    mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC; mem[3] = 8'hDD;
    clear_mon();
    kick(8'd1, AW'(4));
    wait_done();
    total++;
    if (wa.size() !== 4) $display("FAIL basic_count: got %0d want 4", wa.size()); else pass++;
    for (int i = 0; i < wa.size(); i++) begin
      total++;
      if (wa[i] !== AW'(i) || wd[i] !== mem[i])
        $display("FAIL basic_byte%0d: got addr %0d dout %h want addr %0d dout %h", i, wa[i], wd[i], i, mem[i]);
      else pass++;
    end
    for (int i = 1; i < wc.size(); i++) begin
      total++;
      if (wc[i] - wc[i-1] !== PER) $display("FAIL basic_spacing%0d: got %0d want %0d", i, wc[i] - wc[i-1], PER);
      else pass++;
    end
    if (wc.size() > 0) begin
      total++;
      if (wc[0] - dl_rise < 2) $display("FAIL basic_lead: got %0d want >=2", wc[0] - dl_rise); else pass++;
      total++;
      if (dl_fall - wc[wc.size()-1] !== FALL)
        $display("FAIL basic_tail: got %0d want %0d", dl_fall - wc[wc.size()-1], FALL);
      else pass++;
    end
    total++;
    if (done_cnt !== 1 || done_cyc !== dl_fall || done_busy !== 1'b0)
      $display("FAIL basic_done: got cnt %0d cyc %0d busy %b want 1 %0d 0", done_cnt, done_cyc, done_busy, dl_fall);
    else pass++;
    total++;
    if (ioidx !== 8'd1) $display("FAIL basic_index: got %h want 01", ioidx); else pass++;
  endtask
  task automatic test_zero_len();
    clear_mon();
    start = 1'b1;
    index = 8'h5A;
    length = '0;
    tick();
    start = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL zero_done: got done %b busy %b want 1 0", done, busy); else pass++;
    tick();
    total++;
    if (done !== 1'b0) $display("FAIL zero_done_pulse: got %b want 0", done); else pass++;
    tick(6);
    total++;
    if (dl_cnt + rd_cnt + wa.size() !== 0 || done_cnt !== 1)
      $display("FAIL zero_quiet: got dl %0d rd %0d wr %0d done %0d want 0 0 0 1", dl_cnt, rd_cnt, wa.size(), done_cnt);
    else pass++;
  endtask
  task automatic test_wait();
    int w, n;
    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
    clear_mon();
    kick(8'd1, AW'(4));
    wait_wr(2);
    wt = 1'b1;
    w = wc.size() >= 2 ? wc[1] + PER : cyc;
    n = 0;
    while (cyc < w + 10 && n < 400) begin
      if (cyc >= w) begin
        total++;
        if (addr !== AW'(2) || dout !== mem[2] || wr !== 1'b0)
          $display("FAIL wait_hold@%0d: got addr %0d dout %h wr %b want 2 %h 0", cyc - w, addr, dout, wr, mem[2]);
        else pass++;
      end
      tick();
      n++;
    end
    wt = 1'b0;
    wait_done();
    total++;
    if (wa.size() !== 4) $display("FAIL wait_count: got %0d want 4", wa.size()); else pass++;
    if (wc.size() >= 3) begin
      total++;
      if (wc[2] !== w + 10) $display("FAIL wait_delay: got %0d want %0d", wc[2], w + 10); else pass++;
    end
    for (int i = 0; i < wa.size(); i++) begin
      total++;
      if (wa[i] !== AW'(i) || wd[i] !== mem[i])
        $display("FAIL wait_byte%0d: got %0d %h want %0d %h", i, wa[i], wd[i], i, mem[i]);
      else pass++;
    end
  endtask
  task automatic test_ignored_start();
    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
    clear_mon();
    kick(8'd1, AW'(4));
    wait_wr(1);
    kick(8'd0, AW'(2));
    wait_done();
    total++;
    if (wa.size() !== 4 || ioidx !== 8'd1 || done_cnt !== 1)
      $display("FAIL ignored_start: got wr %0d index %h done %0d want 4 01 1", wa.size(), ioidx, done_cnt);
    else pass++;
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
    clear_mon();
    kick(8'd1, AW'(4));
    wait_wr(3);
    rst_n = 1'b0;
    tick();
    total++;
    if (dl !== 1'b0 || wr !== 1'b0 || busy !== 1'b0)
      $display("FAIL midreset_outputs: got dl %b wr %b busy %b want 0 0 0", dl, wr, busy);
    else pass++;
    rst_n = 1'b1;
    tick(40);
    total++;
    if (wa.size() !== 3 || done_cnt !== 0)
      $display("FAIL midreset_quiet: got wr %0d done %0d want 3 0", wa.size(), done_cnt);
    else pass++;
    clear_mon();
    kick(8'd2, AW'(1));
    wait_done();
    total++;
    if (wa.size() !== 1 || done_cnt !== 1) $display("FAIL restart_count: got wr %0d done %0d want 1 1", wa.size(), done_cnt);
    else if (wa[0] !== '0 || wd[0] !== mem[0])
      $display("FAIL restart_byte: got %0d %h want 0 %h", wa[0], wd[0], mem[0]);
    else pass++;
  endtask
  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int len, n, errs, gaps;
      logic [7:0] idx, sum;
      len = $urandom_range(1, 12);
      idx = 8'($urandom);
      sum = 8'd0;
      for (int i = 0; i < len; i++) begin
        mem[i] = 8'($urandom);
        sum += mem[i];
      end
      clear_mon();
      kick(idx, AW'(len));
      n = 0;
      while (done_cnt == 0 && n < 3000) begin
        wt = $urandom_range(0, 3) == 0;
        tick();
        n++;
      end
      wt = 1'b0;
      tick(2);
      total++;
      if (wa.size() !== len || done_cnt !== 1 || ioidx !== idx)
        $display("FAIL rand%0d_shape: got wr %0d done %0d idx %h want %0d 1 %h", it, wa.size(), done_cnt, ioidx, len, idx);
      else pass++;
      errs = 0;
      gaps = 0;
      for (int i = 0; i < wa.size(); i++) begin
        if (wa[i] !== AW'(i) || wd[i] !== mem[i]) errs++;
        if (i > 0 && wc[i] - wc[i-1] < PER) gaps++;
      end
      total++;
      if (errs + gaps !== 0) $display("FAIL rand%0d_bytes: got %0d bad bytes %0d short gaps want 0 0", it, errs, gaps);
      else pass++;
`ifdef IOCTL_SRC_CHECKSUM_EN
      total++;
      if (done_ck !== sum) $display("FAIL rand%0d_checksum: got %h want %h", it, done_ck, sum); else pass++;
`endif
    end
  endtask
`ifdef IOCTL_SRC_CHECKSUM_EN
  task automatic test_checksum();
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'hFF;
    clear_mon();
    kick(8'd0, AW'(3));
    wait_done();
    total++;
    if (done_ck !== 8'h02 || csum !== 8'h02) $display("FAIL checksum_done: got %h/%h want 02", done_ck, csum); else pass++;
    clear_mon();
    kick(8'd0, AW'(2));
    total++;
    if (csum !== 8'h00) $display("FAIL checksum_clear: got %h want 00", csum); else pass++;
    wait_done();
  endtask
`endif
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    clear_mon();
    test_reset();
    test_basic();
    test_zero_len();
    test_wait();
    test_ignored_start();
    test_reset_mid();
    test_random();
`ifdef IOCTL_SRC_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
